// File: rtl/dcache_resp.sv
// Direct-mapped, write-back, write-allocate data cache (one 16-bit word per line)
// answering MEM-stage Rd/Wr requests, backed by a fixed-latency internal word memory.
module dcache_resp #(
    parameter int IDX_W   = 3,
    parameter int MEM_AW  = 12,
    parameter int MEM_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        Err
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 15 - IDX_W;
    localparam int WORDS = 1 << MEM_AW;
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_t;
    typedef enum logic [2:0] {
        UPD_NONE, UPD_HIT_RD, UPD_HIT_WR, UPD_INSTALL_WR, UPD_INSTALL_RD
    } upd_t;

    state_t             state, state_next;
    upd_t               upd;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               mem_we;

    logic [15:1]        req_addr;
    logic [15:0]        req_data;
    logic               req_rd;
    logic               hit_q;
    logic               err_q;

    logic [LINES-1:0]   line_valid;
    logic [LINES-1:0]   line_dirty;
    logic [TAG_W-1:0]   line_tag  [LINES];
    logic [15:0]        line_word [LINES];
    logic [15:0]        mem       [WORDS];

    logic [15:1]        cur_addr;
    logic [15:0]        cur_data;
    logic [IDX_W-1:0]   cur_idx;
    logic [TAG_W-1:0]   cur_tag;
    logic [MEM_AW-1:0]  fill_addr;
    logic [MEM_AW-1:0]  wb_addr;
    logic [15:0]        fill_word;
    logic               accept;
    logic               in_err;
    logic               line_hit;
    logic               victim_dirty;
    logic               last;

    // In IDLE the request is decided straight from the ports; afterwards the latched copy rules.
    assign cur_addr     = (state == S_IDLE) ? Addr[15:1] : req_addr;
    assign cur_data     = (state == S_IDLE) ? DataIn : req_data;
    assign cur_idx      = cur_addr[IDX_W:1];
    assign cur_tag      = cur_addr[15:IDX_W+1];
    assign fill_addr    = cur_addr[MEM_AW:1];
    assign wb_addr      = MEM_AW'({line_tag[cur_idx], cur_idx});
    assign fill_word    = mem[fill_addr];

    assign accept       = (state == S_IDLE) && (Rd || Wr);
    assign in_err       = (Rd && Wr) || Addr[0];
    assign line_hit     = line_valid[cur_idx] && (line_tag[cur_idx] == cur_tag);
    assign victim_dirty = line_valid[cur_idx] && line_dirty[cur_idx];
    assign last         = (cnt == CNT_W'(MEM_LAT - 1));

    assign Done     = (state == S_DONE);
    assign Stall    = (state == S_WB) || (state == S_FILL);
    assign CacheHit = Done && hit_q;
    assign Err      = Done && err_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        upd        = UPD_NONE;
        mem_we     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (in_err) begin
                        state_next = S_DONE;
                    end else if (line_hit) begin
                        state_next = S_DONE;
                        upd        = Wr ? UPD_HIT_WR : UPD_HIT_RD;
                    end else if (victim_dirty) begin
                        state_next = S_WB;
                        cnt_next   = '0;
                    end else if (Rd) begin
                        state_next = S_FILL;
                        cnt_next   = '0;
                    end else begin
                        state_next = S_DONE;
                        upd        = UPD_INSTALL_WR;
                    end
                end
            end
            S_WB: begin
                if (last) begin
                    mem_we   = 1'b1;
                    cnt_next = '0;
                    if (req_rd) begin
                        state_next = S_FILL;
                    end else begin
                        state_next = S_DONE;
                        upd        = UPD_INSTALL_WR;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_FILL: begin
                if (last) begin
                    state_next = S_DONE;
                    upd        = UPD_INSTALL_RD;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            req_addr   <= '0;
            req_data   <= '0;
            req_rd     <= 1'b0;
            hit_q      <= 1'b0;
            err_q      <= 1'b0;
            line_valid <= '0;
            line_dirty <= '0;
            DataOut    <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                req_addr <= Addr[15:1];
                req_data <= DataIn;
                req_rd   <= Rd;
                hit_q    <= !in_err && line_hit;
                err_q    <= in_err;
            end
            case (upd)
                UPD_HIT_RD: DataOut <= line_word[cur_idx];
                UPD_HIT_WR: line_dirty[cur_idx] <= 1'b1;
                UPD_INSTALL_WR: begin
                    line_valid[cur_idx] <= 1'b1;
                    line_dirty[cur_idx] <= 1'b1;
                end
                UPD_INSTALL_RD: begin
                    line_valid[cur_idx] <= 1'b1;
                    line_dirty[cur_idx] <= 1'b0;
                    DataOut             <= fill_word;
                end
                default: ;
            endcase
        end
    end

    // NOTE: tags, line words and backing memory carry no reset; valid bits alone make them meaningful.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wb_addr] <= line_word[cur_idx];
        end
        case (upd)
            UPD_HIT_WR: line_word[cur_idx] <= cur_data;
            UPD_INSTALL_WR: begin
                line_tag[cur_idx]  <= cur_tag;
                line_word[cur_idx] <= cur_data;
            end
            UPD_INSTALL_RD: begin
                line_tag[cur_idx]  <= cur_tag;
                line_word[cur_idx] <= fill_word;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_resp.sv
// Self-checking bench for dcache_resp: directed vector table, hand-written corner sequences,
// then random requests compared against a rule-level cache/memory model.
module tb_dcache_resp;
    logic        clk;
    logic        rst;
    logic        Rd;
    logic        Wr;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        Err;

    int total = 0;
    int bad   = 0;

    dcache_resp #(.IDX_W(3), .MEM_AW(12), .MEM_LAT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .Rd       (Rd),
        .Wr       (Wr),
        .Addr     (Addr),
        .DataIn   (DataIn),
        .DataOut  (DataOut),
        .Done     (Done),
        .Stall    (Stall),
        .CacheHit (CacheHit),
        .Err      (Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-line contents plus word memory with a "known" flag for never-written words.
    logic [15:0] m_word  [8];
    logic [11:0] m_tag   [8];
    bit          m_valid [8];
    bit          m_dirty [8];
    bit          m_known [8];
    logic [15:0] mem_val   [4096];
    bit          mem_known [4096];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        int          lat;
        bit          hit;
        bit          err;
        logic [15:0] dout;
        bit          chk_dout;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic model_req(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                             output int lat, output bit hit, output bit err,
                             output logic [15:0] dout, output bit dknown);
        int idx;
        int m;
        int vm;
        logic [11:0] t;
        idx = int'(a[3:1]);
        t   = a[15:4];
        m   = int'(a[12:1]);
        lat = 1; hit = 0; err = 0; dout = '0; dknown = 0;
        if ((rd && wr) || a[0]) begin
            err = 1;
            return;
        end
        if (m_valid[idx] && m_tag[idx] == t) begin
            hit = 1;
            if (wr) begin
                m_word[idx]  = d;
                m_known[idx] = 1;
                m_dirty[idx] = 1;
            end else begin
                dout   = m_word[idx];
                dknown = m_known[idx];
            end
            return;
        end
        if (m_valid[idx] && m_dirty[idx]) begin
            vm            = (int'(m_tag[idx]) * 8 + idx) % 4096;
            mem_val[vm]   = m_word[idx];
            mem_known[vm] = m_known[idx];
            lat += 4;
        end
        if (rd) begin
            lat += 4;
            m_word[idx]  = mem_val[m];
            m_known[idx] = mem_known[m];
            m_dirty[idx] = 0;
            dout         = m_word[idx];
            dknown       = m_known[idx];
        end else begin
            m_word[idx]  = d;
            m_known[idx] = 1;
            m_dirty[idx] = 1;
        end
        m_valid[idx] = 1;
        m_tag[idx]   = t;
    endtask

    // Issues one request from IDLE and waits (bounded) for Done, recording latency and outputs.
    task automatic run_req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                           input bit scramble, output int lat, output bit hit, output bit err,
                           output logic [15:0] dout, output bit stall_ok);
        @(negedge clk);
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        @(negedge clk);
        lat = 1;
        stall_ok = 1;
        if (!scramble) begin
            Rd = 1'b0;
            Wr = 1'b0;
        end
        while (!Done && lat < 40) begin
            if (!Stall) stall_ok = 0;
            if (scramble) begin
                Addr   = 16'($urandom());
                DataIn = 16'($urandom());
            end
            @(negedge clk);
            lat++;
        end
        if (Stall) stall_ok = 0;
        hit  = CacheHit;
        err  = Err;
        dout = DataOut;
        Rd = 1'b0;
        Wr = 1'b0;
    endtask

    task automatic check_req(input string nm, input int lat, input int exp_lat, input bit hit,
                             input bit exp_hit, input bit err, input bit exp_err,
                             input logic [15:0] dout, input logic [15:0] exp_dout,
                             input bit chk_dout, input bit stall_ok);
        check({nm, " latency"}, lat, exp_lat);
        check({nm, " hit"}, hit, exp_hit);
        check({nm, " err"}, err, exp_err);
        check({nm, " stall"}, stall_ok, 1'b1);
        if (chk_dout) check({nm, " data"}, dout, exp_dout);
    endtask

    initial begin
        int lat, e_lat;
        bit hit, err, stall_ok, e_hit, e_err, e_known;
        logic [15:0] dout, e_dout;
        int pulses;
        logic [11:0] tags [4];

        vecs[0] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1, 1'b1, 1'b0, 16'hBEEF, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 9, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 5, 1'b0, 1'b0, 16'hBEEF, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 16'h0011, 16'h0000, 1, 1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 16'h0010, 16'h0000, 1, 1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1, 1'b1, 1'b0, 16'hBEEF, 1'b1};

        Rd = 0; Wr = 0; Addr = 0; DataIn = 0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1 check("reset outputs", {DataOut, Done, Stall, CacheHit, Err}, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            model_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, e_lat, e_hit, e_err, e_dout, e_known);
            run_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, 1'b0, lat, hit, err, dout, stall_ok);
            check_req($sformatf("vec%0d", i), lat, vecs[i].lat, hit, vecs[i].hit, err, vecs[i].err,
                      dout, vecs[i].dout, vecs[i].chk_dout, stall_ok);
        end

        // Dirty line for 0x0020, then a read of 0x0010 with the address bus churning during Stall.
        model_req(1'b0, 1'b1, 16'h0020, 16'h5A5A, e_lat, e_hit, e_err, e_dout, e_known);
        run_req(1'b0, 1'b1, 16'h0020, 16'h5A5A, 1'b0, lat, hit, err, dout, stall_ok);
        check_req("wr20", lat, 1, hit, 1'b0, err, 1'b0, dout, 16'h0, 1'b0, stall_ok);
        model_req(1'b1, 1'b0, 16'h0010, 16'h0000, e_lat, e_hit, e_err, e_dout, e_known);
        run_req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, lat, hit, err, dout, stall_ok);
        check_req("held rd10", lat, 9, hit, 1'b0, err, 1'b0, dout, 16'hBEEF, 1'b1, stall_ok);

        // Rd held high: Done must alternate, a request seen during Done waits one cycle.
        @(negedge clk);
        Rd = 1'b1; Addr = 16'h0010;
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i % 2 == 1) begin
                check($sformatf("b2b done c%0d", i), Done, 1'b1);
                check($sformatf("b2b hit c%0d", i), CacheHit, 1'b1);
                check($sformatf("b2b data c%0d", i), DataOut, 16'hBEEF);
                if (i == 19) Rd = 1'b0;
            end else begin
                check($sformatf("b2b idle c%0d", i), Done, 1'b0);
            end
            if (Done) pulses++;
        end
        check("b2b pulse count", pulses, 10);

        // Reset inside the writeback of a dirty line must abort it without touching memory.
        model_req(1'b0, 1'b1, 16'h0010, 16'h1234, e_lat, e_hit, e_err, e_dout, e_known);
        run_req(1'b0, 1'b1, 16'h0010, 16'h1234, 1'b0, lat, hit, err, dout, stall_ok);
        check_req("wr10 1234", lat, 1, hit, 1'b1, err, 1'b0, dout, 16'h0, 1'b0, stall_ok);
        @(negedge clk);
        Rd = 1'b1; Addr = 16'h0020;
        @(negedge clk);
        check("wb stall before reset", Stall, 1'b1);
        Rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 check("mid-op reset outputs", {DataOut, Done, Stall, CacheHit, Err}, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        model_req(1'b1, 1'b0, 16'h0010, 16'h0000, e_lat, e_hit, e_err, e_dout, e_known);
        run_req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, lat, hit, err, dout, stall_ok);
        check_req("rd10 after reset", lat, 5, hit, 1'b0, err, 1'b0, dout, 16'hBEEF, 1'b1, stall_ok);
        check("aborted wb not in memory", dout == 16'h1234, 1'b0);

        // Random traffic over a few tags per index, including a tag aliasing beyond the memory range.
        tags[0] = 12'h000; tags[1] = 12'h001; tags[2] = 12'h002; tags[3] = 12'h200;
        for (int n = 0; n < 300; n++) begin
            logic [15:0] a, d;
            logic rd, wr;
            int r;
            bit scr;
            a = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 1'b0};
            if ($urandom_range(0, 19) == 0) a[0] = 1'b1;
            r = $urandom_range(0, 99);
            rd = (r < 50);
            wr = (r >= 50) || (r < 4);
            d = 16'($urandom());
            scr = ($urandom_range(0, 3) == 0);
            model_req(rd, wr, a, d, e_lat, e_hit, e_err, e_dout, e_known);
            run_req(rd, wr, a, d, scr, lat, hit, err, dout, stall_ok);
            check_req($sformatf("rnd%0d a=%h rd=%0b wr=%0b", n, a, rd, wr), lat, e_lat, hit, e_hit,
                      err, e_err, dout, e_dout, rd && !wr && !e_err && e_known, stall_ok);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
